xpar_mbox: RTL and testbench



---
 rtl/xpar_mbox.sv | 208 ++++++++++++++++++++
 tb/tb_xpar_mbox.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xpar_mbox.sv
// Host/device mailbox: a host register port (DATA/STATUS/CTRL/ERR) over an H2D and a D2H FIFO.
// Latency: host reads are combinational; pushes and pops land at the clock edge; irq is registered.
// Backpressure: dev_tx_ready drops when D2H is full; a host push into a full H2D is dropped unless popped that cycle.
//
// Ports:
//   clk, rst (async active-low)
//   par_addr/par_out/par_we/par_re -> par_in : host register access, par_addr[1:0] selects
//       0 DATA, 1 STATUS, 2 CTRL, 3 ERR
//   dev_rx_data/dev_rx_valid/dev_rx_ready : H2D head toward the device
//   dev_tx_data/dev_tx_valid/dev_tx_ready : device push into D2H
//   irq : level interrupt, irq_en & (D2H not empty | any error flag)
// Optional feature: define XPAR_MBOX_ERR_EN for sticky write-1-to-clear error flags in ERR.
// FIFO_DEPTH must be a power of two in 2..128 so pointers wrap naturally.
module xpar_mbox #(
    parameter int DATA_W     = 32,
    parameter int PADDR_W    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PADDR_W-1:0] par_addr,
    input  logic [DATA_W-1:0]  par_out,
    input  logic               par_we,
    input  logic               par_re,
    output logic [DATA_W-1:0]  par_in,
    output logic [DATA_W-1:0]  dev_rx_data,
    output logic               dev_rx_valid,
    input  logic               dev_rx_ready,
    input  logic [DATA_W-1:0]  dev_tx_data,
    input  logic               dev_tx_valid,
    output logic               dev_tx_ready,
    output logic               irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Only the low two address bits are decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^par_addr[PADDR_W-1:2];

    logic [1:0] sel;
    logic       host_rd;
    logic       data_wr, ctrl_wr, data_rd, flush;

    logic [DATA_W-1:0] h2d_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] d2h_mem_q [FIFO_DEPTH];
    logic [AW-1:0] h2d_wp_q, h2d_wp_d, h2d_rp_q, h2d_rp_d;
    logic [AW-1:0] d2h_wp_q, d2h_wp_d, d2h_rp_q, d2h_rp_d;
    logic [CW-1:0] h2d_cnt_q, h2d_cnt_d, d2h_cnt_q, d2h_cnt_d;
    logic          irq_en_q, irq_en_d, irq_q, irq_d;

    logic h2d_full, h2d_empty, d2h_full, d2h_empty;
    logic h2d_push, h2d_pop, d2h_push, d2h_pop;
    logic err_any;
    logic [DATA_W-1:0] err_rd;
    logic [DATA_W-1:0] status;

    // A simultaneous write wins over a read: the read neither returns data nor pops.
    assign sel     = par_addr[1:0];
    assign host_rd = par_re & ~par_we;
    assign data_wr = par_we & (sel == 2'd0);
    assign ctrl_wr = par_we & (sel == 2'd2);
    assign data_rd = host_rd & (sel == 2'd0);
    assign flush   = ctrl_wr & par_out[1];

    assign h2d_full  = (h2d_cnt_q == CNT_FULL);
    assign h2d_empty = (h2d_cnt_q == '0);
    assign d2h_full  = (d2h_cnt_q == CNT_FULL);
    assign d2h_empty = (d2h_cnt_q == '0);

    // A push into a full FIFO is still taken when the same cycle frees a slot.
    assign h2d_pop  = ~h2d_empty & dev_rx_ready;
    assign h2d_push = data_wr & (~h2d_full | h2d_pop);
    assign d2h_pop  = data_rd & ~d2h_empty;
    assign d2h_push = dev_tx_valid & (~d2h_full | d2h_pop);

`ifdef XPAR_MBOX_ERR_EN
    logic       err_wr, h2d_drop, d2h_drop, d2h_udf;
    logic [2:0] err_q, err_d;

    assign err_wr   = par_we & (sel == 2'd3);
    assign h2d_drop = data_wr & h2d_full & ~h2d_pop;
    assign d2h_drop = dev_tx_valid & d2h_full & ~d2h_pop;
    assign d2h_udf  = data_rd & d2h_empty;

    // Clear first, then set, so a same-cycle set survives the clear.
    always_comb begin
        err_d = err_q;
        if (err_wr) begin
            err_d = err_q & ~par_out[2:0];
        end
        err_d = err_d | {d2h_udf, d2h_drop, h2d_drop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_any = |err_q;
    assign err_rd  = {{(DATA_W-3){1'b0}}, err_q};
`else
    assign err_any = 1'b0;
    assign err_rd  = '0;
`endif

    always_comb begin
        h2d_wp_d  = h2d_wp_q;
        h2d_rp_d  = h2d_rp_q;
        h2d_cnt_d = h2d_cnt_q;
        d2h_wp_d  = d2h_wp_q;
        d2h_rp_d  = d2h_rp_q;
        d2h_cnt_d = d2h_cnt_q;

        if (h2d_push) h2d_wp_d = h2d_wp_q + PTR_ONE;
        if (h2d_pop)  h2d_rp_d = h2d_rp_q + PTR_ONE;
        case ({h2d_push, h2d_pop})
            2'b10:   h2d_cnt_d = h2d_cnt_q + CNT_ONE;
            2'b01:   h2d_cnt_d = h2d_cnt_q - CNT_ONE;
            default: h2d_cnt_d = h2d_cnt_q;
        endcase

        if (d2h_push) d2h_wp_d = d2h_wp_q + PTR_ONE;
        if (d2h_pop)  d2h_rp_d = d2h_rp_q + PTR_ONE;
        case ({d2h_push, d2h_pop})
            2'b10:   d2h_cnt_d = d2h_cnt_q + CNT_ONE;
            2'b01:   d2h_cnt_d = d2h_cnt_q - CNT_ONE;
            default: d2h_cnt_d = d2h_cnt_q;
        endcase

        // Flush overrides any push/pop in the same cycle.
        if (flush) begin
            h2d_wp_d  = '0;
            h2d_rp_d  = '0;
            h2d_cnt_d = '0;
            d2h_wp_d  = '0;
            d2h_rp_d  = '0;
            d2h_cnt_d = '0;
        end

        irq_en_d = ctrl_wr ? par_out[0] : irq_en_q;
        irq_d    = irq_en_q & (~d2h_empty | err_any);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h2d_wp_q  <= '0;
            h2d_rp_q  <= '0;
            h2d_cnt_q <= '0;
            d2h_wp_q  <= '0;
            d2h_rp_q  <= '0;
            d2h_cnt_q <= '0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            h2d_wp_q  <= h2d_wp_d;
            h2d_rp_q  <= h2d_rp_d;
            h2d_cnt_q <= h2d_cnt_d;
            d2h_wp_q  <= d2h_wp_d;
            d2h_rp_q  <= d2h_rp_d;
            d2h_cnt_q <= d2h_cnt_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
        end
    end

    // Storage is not reset; the counts alone decide what is valid.
    always_ff @(posedge clk) begin
        if (h2d_push) h2d_mem_q[h2d_wp_q] <= par_out;
        if (d2h_push) d2h_mem_q[d2h_wp_q] <= dev_tx_data;
    end

    always_comb begin
        status            = '0;
        status[0]         = h2d_full;
        status[1]         = h2d_empty;
        status[2]         = d2h_full;
        status[3]         = d2h_empty;
        status[8 +: CW]   = h2d_cnt_q;
        status[16 +: CW]  = d2h_cnt_q;
    end

    // Read data is forced to zero while in reset so STATUS cannot leak its empty flags.
    always_comb begin
        par_in = '0;
        if (rst && host_rd) begin
            case (sel)
                2'd0:    par_in = d2h_empty ? '0 : d2h_mem_q[d2h_rp_q];
                2'd1:    par_in = status;
                2'd2:    par_in[0] = irq_en_q;
                default: par_in = err_rd;
            endcase
        end
    end

    assign dev_rx_valid = ~h2d_empty;
    assign dev_rx_data  = h2d_empty ? '0 : h2d_mem_q[h2d_rp_q];
    assign dev_tx_ready = ~d2h_full;
    assign irq          = irq_q;

endmodule

// File: tb/tb_xpar_mbox.sv
module tb_xpar_mbox;
    localparam int DATA_W  = 32;
    localparam int PADDR_W = 16;
    localparam int DEPTH   = 8;
`ifdef XPAR_MBOX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [PADDR_W-1:0] par_addr = '0;
    logic [DATA_W-1:0]  par_out = '0;
    logic               par_we = 1'b0;
    logic               par_re = 1'b0;
    logic [DATA_W-1:0]  par_in;
    logic [DATA_W-1:0]  dev_rx_data;
    logic               dev_rx_valid;
    logic               dev_rx_ready = 1'b0;
    logic [DATA_W-1:0]  dev_tx_data = '0;
    logic               dev_tx_valid = 1'b0;
    logic               dev_tx_ready;
    logic               irq;

    xpar_mbox #(.DATA_W(DATA_W), .PADDR_W(PADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .par_addr     (par_addr),
        .par_out      (par_out),
        .par_we       (par_we),
        .par_re       (par_re),
        .par_in       (par_in),
        .dev_rx_data  (dev_rx_data),
        .dev_rx_valid (dev_rx_valid),
        .dev_rx_ready (dev_rx_ready),
        .dev_tx_data  (dev_tx_data),
        .dev_tx_valid (dev_tx_valid),
        .dev_tx_ready (dev_tx_ready),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: two bounded queues plus the host-visible control state.
    logic [31:0] h2d_m[$];
    logic [31:0] d2h_m[$];
    bit          m_irq_en = 1'b0;
    bit          m_irq    = 1'b0;
    logic [2:0]  m_err    = 3'b000;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] status_m();
        logic [31:0] s;
        int hc;
        int dc;
        hc = h2d_m.size();
        dc = d2h_m.size();
        s = '0;
        s[0] = (hc == DEPTH);
        s[1] = (hc == 0);
        s[2] = (dc == DEPTH);
        s[3] = (dc == 0);
        s[15:8] = 8'(hc);
        s[23:16] = 8'(dc);
        return s;
    endfunction

    function automatic logic [31:0] exp_par_in();
        if (!par_re || par_we) return '0;
        case (par_addr[1:0])
            2'd0:    return (d2h_m.size() != 0) ? d2h_m[0] : '0;
            2'd1:    return status_m();
            2'd2:    return {31'b0, m_irq_en};
            default: return ERR_EN ? {29'b0, m_err} : '0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    function automatic void model_next();
        bit         wr;
        bit         rd;
        logic [1:0] a;
        bit         irq_src;
        bit         d_had;
        logic [2:0] set;
        logic [2:0] clr;
        wr = par_we;
        rd = par_re && !par_we;
        a = par_addr[1:0];
        set = 3'b000;
        irq_src = (d2h_m.size() != 0) || (ERR_EN && (m_err != 3'b000));

        if (h2d_m.size() != 0 && dev_rx_ready) void'(h2d_m.pop_front());
        if (wr && a == 2'd0) begin
            if (h2d_m.size() < DEPTH) h2d_m.push_back(par_out);
            else set[0] = 1'b1;
        end

        d_had = (d2h_m.size() != 0);
        if (rd && a == 2'd0) begin
            if (d_had) void'(d2h_m.pop_front());
            else set[2] = 1'b1;
        end
        if (dev_tx_valid) begin
            if (d2h_m.size() < DEPTH) d2h_m.push_back(dev_tx_data);
            else set[1] = 1'b1;
        end

        if (wr && a == 2'd2 && par_out[1]) begin
            h2d_m.delete();
            d2h_m.delete();
        end

        m_irq = m_irq_en && irq_src;
        if (wr && a == 2'd2) m_irq_en = par_out[0];
        if (ERR_EN) begin
            clr = (wr && a == 2'd3) ? par_out[2:0] : 3'b000;
            m_err = (m_err & ~clr) | set;
        end
    endfunction

    task automatic drive(input bit we, input bit re, input logic [1:0] a, input logic [31:0] d,
                         input bit txv, input logic [31:0] txd, input bit rxr);
        par_we       = we;
        par_re       = re;
        par_addr     = {14'($urandom), a};
        par_out      = d;
        dev_tx_valid = txv;
        dev_tx_data  = txd;
        dev_rx_ready = rxr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // One clock: compare combinational outputs mid-cycle, then irq after the edge.
    task automatic step();
        logic [31:0] e_in;
        logic [31:0] e_rx;
        e_in = exp_par_in();
        e_rx = (h2d_m.size() != 0) ? h2d_m[0] : '0;
        @(negedge clk);
        check("par_in", par_in, e_in);
        check("dev_rx_valid", dev_rx_valid, h2d_m.size() != 0);
        check("dev_rx_data", dev_rx_data, e_rx);
        check("dev_tx_ready", dev_tx_ready, d2h_m.size() < DEPTH);
        model_next();
        @(posedge clk);
        #1;
        check("irq", irq, m_irq);
    endtask

    initial begin
        // Reset state
        drive(1'b0, 1'b1, 2'd1, 32'h0, 1'b0, 32'h0, 1'b0);
        #2;
        check("rst_par_in", par_in, 32'h0);
        check("rst_rx_valid", dev_rx_valid, 1'b0);
        check("rst_tx_ready", dev_tx_ready, 1'b1);
        check("rst_irq", irq, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();

        // Fill H2D with 0x11..0x18, then overflow with 0x99
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 2'd0, 32'h11 + i, 1'b0, 32'h0, 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 2'd1, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check("status_h2d_full", par_in, 32'h0000_0809);
        step();
        drive(1'b1, 1'b0, 2'd0, 32'h99, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b1, 2'd3, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check("err_h2d_ovf", par_in, ERR_EN ? 32'h1 : 32'h0);
        step();

        // Drain H2D; the dropped 0x99 must not appear
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b1);
            #1;
            check("drain_data", dev_rx_data, 32'h11 + i);
            step();
        end
        idle();
        #1;
        check("drain_done_valid", dev_rx_valid, 1'b0);
        drive(1'b1, 1'b0, 2'd3, 32'h7, 1'b0, 32'h0, 1'b0);
        step();

        // Interrupt on D2H data
        drive(1'b1, 1'b0, 2'd2, 32'h1, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0);
        step();
        idle();
        step();
        check("irq_after_push", irq, 1'b1);
        drive(1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check("irq_read_data", par_in, 32'hA5A5A5A5);
        step();
        idle();
        step();
        check("irq_cleared", irq, 1'b0);

        // Empty-read, then both FIFOs around the full boundary
        drive(1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check("empty_read_zero", par_in, 32'h0);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 32'hD000 + i, 1'b0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 2'd0, 32'h4000 + i, 1'b0, 32'h0, 1'b0);
            step();
        end
        drive(1'b1, 1'b0, 2'd0, 32'h77, 1'b1, 32'hBB, 1'b1);
        step();
        drive(1'b1, 1'b1, 2'd0, 32'h78, 1'b0, 32'h0, 1'b0);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(1'($urandom), 1'($urandom), 2'd0, $urandom, 1'($urandom), $urandom, 1'($urandom));
            step();
        end

        // Flush in the same cycle as a device push
        drive(1'b1, 1'b0, 2'd2, 32'h2, 1'b1, 32'hCC, 1'b0);
        step();
        drive(1'b0, 1'b1, 2'd1, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check("status_after_flush", par_in, 32'h0000_000A);
        step();

        // Asynchronous reset with three words held in H2D
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 2'd0, 32'h300 + i, 1'b0, 32'h0, 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 2'd1, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        check("arst_rx_valid", dev_rx_valid, 1'b0);
        check("arst_tx_ready", dev_tx_ready, 1'b1);
        check("arst_par_in", par_in, 32'h0);
        rst = 1'b1;
        #1;
        check("arst_status", par_in, 32'h0000_000A);
        h2d_m.delete();
        d2h_m.delete();
        m_irq_en = 1'b0;
        m_irq = 1'b0;
        m_err = 3'b000;
        step();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit         we;
            bit         re;
            logic [1:0] a;
            logic [31:0] d;
            we = ($urandom_range(0, 99) < 35);
            re = ($urandom_range(0, 99) < 35);
            a = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            d = $urandom;
            if (a == 2'd2) d[1] = ($urandom_range(0, 19) == 0);
            drive(we, re, a, d, ($urandom_range(0, 99) < 45), $urandom, ($urandom_range(0, 99) < 40));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
